// File: rtl/jt900h_ramwr_pkg.sv
// Shared jt900h width encoding and the state type for the RAM write sequencer.
// jt900h_ramctl callers use the same width codes.
package jt900h_ramwr_pkg;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_WORD = 2'b01,
    W_LONG = 2'b10
  } width_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BEAT = 2'b01,
    ST_DONE = 2'b10
  } ramwr_state_t;

  // Byte-enable mask of a request before alignment; code 11 is a long, like 10.
  function automatic logic [3:0] width_mask(input logic [1:0] w);
    case (w)
      W_BYTE:  width_mask = 4'b0001;
      W_WORD:  width_mask = 4'b0011;
      default: width_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/jt900h_ramwr.sv
// Splits a byte/word/long write at any alignment into 16-bit bus beats,
// steering bytes into lanes with a byte shift register and a pending-byte mask.
module jt900h_ramwr
  import jt900h_ramwr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        req,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_din,
  input  logic [1:0]  req_w,
  output logic        busy,
  output logic        done,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [1:0]  ram_be,
  output logic        ram_we,
  input  logic        ram_wait
);

  ramwr_state_t state;
  logic [31:0]  sh;
  logic [3:0]   pend;
  logic [3:0]   req_mask;

  assign req_mask = width_mask(req_w);

  // The first beat is prepared at acceptance; an odd start puts byte 0 in the
  // odd lane, after which every following beat is halfword aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_we   <= 1'b0;
      ram_be   <= 2'b00;
      ram_addr <= 24'h000000;
      ram_din  <= 16'h0000;
      sh       <= 32'h0;
      pend     <= 4'h0;
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (req) begin
            state    <= ST_BEAT;
            busy     <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= {req_addr[23:1], 1'b0};
            if (req_addr[0]) begin
              ram_be  <= {req_mask[0], 1'b0};
              ram_din <= {req_din[7:0], 8'h00};
              sh      <= {8'h00, req_din[31:8]};
              pend    <= {1'b0, req_mask[3:1]};
            end else begin
              ram_be  <= req_mask[1:0];
              ram_din <= {req_din[15:8] & {8{req_mask[1]}}, req_din[7:0]};
              sh      <= {16'h0000, req_din[31:16]};
              pend    <= {2'b00, req_mask[3:2]};
            end
          end
        end
        ST_BEAT: begin
          if (!ram_wait) begin
            if (pend == 4'h0) begin
              state   <= ST_DONE;
              ram_we  <= 1'b0;
              done    <= 1'b1;
              ram_be  <= 2'b00;
              ram_din <= 16'h0000;
            end else begin
              ram_addr <= ram_addr + 24'd2;
              ram_be   <= pend[1:0];
              ram_din  <= {sh[15:8] & {8{pend[1]}}, sh[7:0] & {8{pend[0]}}};
              sh       <= sh >> 16;
              pend     <= pend >> 2;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_ramwr.sv
// Self-checking bench for jt900h_ramwr: directed cases plus random requests
// compared against a byte-by-byte model of the expected bus beats.
module tb_jt900h_ramwr;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        req;
  logic [23:0] req_addr;
  logic [31:0] req_din;
  logic [1:0]  req_w;
  logic        busy;
  logic        done;
  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_be;
  logic        ram_we;
  logic        ram_wait;

  int vectors = 0;
  int errors  = 0;

  logic [23:0] exp_addr[$];
  logic [1:0]  exp_be[$];
  logic [15:0] exp_din[$];

  jt900h_ramwr dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .req      (req),
    .req_addr (req_addr),
    .req_din  (req_din),
    .req_w    (req_w),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_be   (ram_be),
    .ram_we   (ram_we),
    .ram_wait (ram_wait)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Each written byte lands at addr+i; consecutive bytes sharing a halfword form one beat.
  task automatic buildModel(input logic [23:0] a, input logic [31:0] d, input logic [1:0] w);
    int nbytes;
    logic [23:0] ba;
    logic [7:0]  bv;
    exp_addr.delete(); exp_be.delete(); exp_din.delete();
    nbytes = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) begin
      ba = a + 24'(i);
      bv = 8'(d >> (8 * i));
      if (exp_addr.size() == 0 || exp_addr[exp_addr.size()-1] != {ba[23:1], 1'b0}) begin
        exp_addr.push_back({ba[23:1], 1'b0});
        exp_be.push_back(2'b00);
        exp_din.push_back(16'h0000);
      end
      if (ba[0]) begin
        exp_be[exp_be.size()-1][1]      = 1'b1;
        exp_din[exp_din.size()-1][15:8] = bv;
      end else begin
        exp_be[exp_be.size()-1][0]     = 1'b1;
        exp_din[exp_din.size()-1][7:0] = bv;
      end
    end
  endtask

  task automatic startReq(input logic [23:0] a, input logic [31:0] d, input logic [1:0] w);
    @(negedge clk);
    req = 1'b1; req_addr = a; req_din = d; req_w = w; cen = 1'b1; ram_wait = 1'b0;
    @(negedge clk);
    req = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("we_after_accept", 32'(ram_we), 32'd1);
  endtask

  // Runs one request to completion with random stalls/cen gaps, optionally
  // hammering req while busy and on the done cycle to prove those are ignored.
  task automatic applyStimulus(input logic [23:0] a, input logic [31:0] d, input logic [1:0] w,
                               input int stallPct, input int cenPct, input bit extraReq);
    int idx = 0;
    int n;
    bit seen = 1'b0;
    buildModel(a, d, w);
    n = exp_addr.size();
    startReq(a, d, w);
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      if (ram_we) begin
        if (idx < n) begin
          checkOutput("beat_addr", 32'(ram_addr), 32'(exp_addr[idx]));
          checkOutput("beat_be", 32'(ram_be), 32'(exp_be[idx]));
          checkOutput("beat_din", 32'(ram_din), 32'(exp_din[idx]));
        end else begin
          checkOutput("extra_beat", 32'(idx), 32'(n - 1));
        end
      end
      if (done) begin
        seen = 1'b1;
        checkOutput("beats_before_done", 32'(idx), 32'(n));
        checkOutput("we_in_done", 32'(ram_we), 32'd0);
        cen = 1'b1; ram_wait = 1'b0;
        req = extraReq; req_addr = 24'($urandom); req_w = 2'($urandom);
      end else begin
        cen      = (int'($urandom_range(0, 99)) < cenPct);
        ram_wait = (int'($urandom_range(0, 99)) < stallPct);
        if (extraReq) begin
          req = 1'($urandom); req_addr = 24'($urandom); req_din = $urandom;
        end
        if (ram_we && cen && !ram_wait) idx++;
      end
      @(negedge clk);
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    req = 1'b0;
    checkOutput("done_pulse_end", 32'(done), 32'd0);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("we_after_done", 32'(ram_we), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; req = 1'b0; req_addr = '0; req_din = '0; req_w = '0; ram_wait = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(ram_we), 32'd0);
    checkOutput("rst_be", 32'(ram_be), 32'd0);
    checkOutput("rst_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_din", 32'(ram_din), 32'd0);
    rst = 1'b0;

    // Directed cases, including the odd word that wraps the address space.
    applyStimulus(24'h001235, 32'h000000AB, 2'b00, 0, 100, 1'b0);
    applyStimulus(24'h000100, 32'h44332211, 2'b10, 0, 100, 1'b0);
    applyStimulus(24'h000101, 32'h44332211, 2'b10, 0, 100, 1'b0);
    applyStimulus(24'hFFFFFF, 32'h0000BBAA, 2'b01, 0, 100, 1'b0);
    applyStimulus(24'h000101, 32'h44332211, 2'b11, 0, 100, 1'b0);
    applyStimulus(24'h000200, 32'hDDCCBBAA, 2'b10, 60, 50, 1'b1);

    // Reset in the middle of beat 2 of an odd long write.
    startReq(24'h000301, 32'h87654321, 2'b10);
    checkOutput("abort_beat1_addr", 32'(ram_addr), 32'h000300);
    @(negedge clk);
    checkOutput("abort_beat2_addr", 32'(ram_addr), 32'h000302);
    checkOutput("abort_beat2_din", 32'(ram_din), 32'h00006543);
    rst = 1'b1;
    #1;
    checkOutput("abort_we", 32'(ram_we), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_abort_we", 32'(ram_we), 32'd0);
      checkOutput("post_abort_done", 32'(done), 32'd0);
    end
    applyStimulus(24'h000400, 32'h0BADF00D, 2'b10, 0, 100, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(24'($urandom), $urandom, 2'($urandom), 30, 70, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/jt900h_ramwr.md
JT900H_RAMWR -- requirements
Module: jt900h_ramwr

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port cen, input, 1 bit: clock enable; state advances only when cen=1.
REQ-004 SHALL have port req, input, 1 bit: write request strobe, sampled when busy=0 and cen=1.
REQ-005 SHALL have port req_addr, input, 24 bits: byte address of the write, any alignment.
REQ-006 SHALL have port req_din, input, 32 bits: write data, little-endian, with the byte for req_addr in bits [7:0].
REQ-007 SHALL have port req_w, input, 2 bits: width code, 00=byte, 01=word, 10=long, 11=long.
REQ-008 SHALL have port busy, output, 1 bit: high while a request is being written.
REQ-009 SHALL have port done, output, 1 bit: one-cen-cycle pulse after the last beat is accepted.
REQ-010 SHALL have port ram_addr, output, 24 bits: even bus address; bit 0 is always 0.
REQ-011 SHALL have port ram_din, output, 16 bits: bus write data; even byte on [7:0], odd byte on [15:8].
REQ-012 SHALL have port ram_be, output, 2 bits, active high: bit0 enables the even byte and bit1 enables the odd byte.
REQ-013 SHALL have port ram_we, output, 1 bit: write strobe, high during each beat.
REQ-014 SHALL have port ram_wait, input, 1 bit: bus stall; while it is high, the current beat is held unchanged.

Function
REQ-015 SHALL implement the FSM states IDLE, BEAT and DONE.
REQ-016 In IDLE, req=1 with cen=1 SHALL latch the request and enter BEAT, with busy=1 and ram_we=1 from the next cycle.
REQ-017 SHALL split each request into beats on 16-bit aligned addresses, from lowest to highest.
- Beat counts: byte=1; even word=1; odd word=2; even long=2; odd long=3.
REQ-018 For each beat, SHALL drive:
- ram_addr = {beat address[23:1], 1'b0};
- ram_be = the request bytes that fall in that halfword;
- ram_din with each enabled byte in its lane and disabled lanes at 0.
REQ-019 A beat SHALL complete on a cycle with cen=1 and ram_wait=0.
- On completion, ram_addr SHALL advance by 2.
REQ-020 With ram_wait=0 throughout, a request of N beats SHALL keep ram_we high for exactly N cen cycles.
REQ-021 After the last beat completes, SHALL enter DONE.
- In DONE: ram_we=0 and done=1 for one cen cycle.
- Then SHALL return to IDLE with busy=0.
REQ-022 A req arriving while busy=1 SHALL be ignored; there is no queue.
REQ-023 A req arriving in the same cycle as done=1 SHALL be ignored; it is accepted only in IDLE.
REQ-024 When cen=0, all outputs and state SHALL hold their values.
REQ-025 Address arithmetic SHALL be 24 bits and SHALL wrap from 24'hFFFFFE to 24'h000000 with no error.
REQ-026 A width code of 11 SHALL behave identically to 10.

Reset
REQ-027 While rst=1, SHALL hold the outputs at these values:
- state=IDLE;
- busy=0, done=0, ram_we=0;
- ram_be=0, ram_addr=0, ram_din=0.
REQ-028 A reset during BEAT SHALL abort the request immediately; no further beat and no done pulse SHALL follow.

Structure
REQ-029 Width codes (BYTE/WORD/LONG) SHALL be defined in the shared jt900h include, because jt900h_ramctl callers use the same encoding.
REQ-030 The block SHALL be a single module with no sub-modules.
- Lane steering SHALL be a byte shift register plus a 4-bit pending-byte mask.

Verification
REQ-031 req_w=00, addr=24'h001235, din=32'h000000AB
- -> one beat: ram_addr=24'h001234, ram_be=2'b10, ram_din=16'hAB00;
- -> done one cycle later.
REQ-032 req_w=10, addr=24'h000100, din=32'h44332211
- -> beat 1: addr 24'h000100, be=11, din=16'h2211;
- -> beat 2: addr 24'h000102, be=11, din=16'h4433.
REQ-033 req_w=10, addr=24'h000101, din=32'h44332211
- -> beat 1: addr 100, be=10, din=16'h1100;
- -> beat 2: addr 102, be=11, din=16'h3322;
- -> beat 3: addr 104, be=01, din=16'h0044.
REQ-034 req_w=01, addr=24'hFFFFFF, din=16'hBBAA
- -> beat 1: addr FFFFFE, be=10, din=16'hAA00;
- -> beat 2: addr 000000, be=01, din=16'h00BB.
REQ-035 Even long write with ram_wait=1 for 3 cycles on beat 1 and with cen toggling
- -> beat 1 outputs stay stable while stalled;
- -> exactly 2 beats are accepted, then one done pulse;
- -> a second req issued while busy=1 produces no beat.
REQ-036 rst asserted during beat 2 of an odd long write
- -> ram_we, busy and done go to 0 at once;
- -> after release, IDLE accepts a new request normally.
